// File: rtl/sr_q_csv_serializer.sv
// Snapshots five Schumann-resonance Q values and streams them as one ASCII CSV line
// ("Qdd,dd,dd,dd,dd\n") per trigger over a valid/ready byte interface.
`timescale 1ns/1ps
module sr_q_csv_serializer #(
  parameter int WIDTH         = 18,
  parameter int NUM_HARMONICS = 5,
  parameter int PERIOD        = 256
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clk_en,
  input  logic                           enable,
  input  logic                           snap_req,
  input  logic [NUM_HARMONICS*WIDTH-1:0] q_scaled_packed,
  output logic [7:0]                     tx_data,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic                           busy,
  output logic [7:0]                     overrun_count
);

  typedef enum logic [2:0] {IDLE, PREFIX, TENS, ONES, SEP, EOL} state_t;

  localparam logic [15:0] LAST_COUNT = 16'(PERIOD - 1);
  localparam logic [2:0]  LAST_IDX   = 3'(NUM_HARMONICS - 1);

  state_t      state, next_state;
  logic [2:0]  idx, next_idx;
  logic [15:0] period_cnt;
  logic        tick, trigger, fire;
  logic [7:0]  tx_byte;
  logic [6:0]  clamped [NUM_HARMONICS];
  logic [3:0]  tens    [NUM_HARMONICS];
  logic [3:0]  ones    [NUM_HARMONICS];

  function automatic logic [6:0] clamp99(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1])
      return 7'd0;
    if (v > WIDTH'(99))
      return 7'd99;
    return v[6:0];
  endfunction

  assign tick    = clk_en && enable && (period_cnt == LAST_COUNT);
  assign trigger = snap_req || tick;
  assign fire    = tx_valid && tx_ready;

  // The period counter only moves while enabled, so it resumes from where it stopped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      period_cnt <= 16'd0;
    else if (clk_en && enable)
      period_cnt <= tick ? 16'd0 : period_cnt + 16'd1;
  end

  always_comb begin
    for (int i = 0; i < NUM_HARMONICS; i++)
      clamped[i] = clamp99(q_scaled_packed[i*WIDTH +: WIDTH]);
  end

  // Digits are frozen at acceptance so later input changes never reach the line in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_HARMONICS; i++) begin
        tens[i] <= 4'd0;
        ones[i] <= 4'd0;
      end
    end else if (trigger && state == IDLE) begin
      for (int i = 0; i < NUM_HARMONICS; i++) begin
        tens[i] <= 4'(clamped[i] / 7'd10);
        ones[i] <= 4'(clamped[i] % 7'd10);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      overrun_count <= 8'd0;
    else if (trigger && state != IDLE && overrun_count != 8'hFF)
      overrun_count <= overrun_count + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= 3'd0;
    end else begin
      state <= next_state;
      idx   <= next_idx;
    end
  end

  // The byte is decoded from the held state, so it stays stable under backpressure.
  always_comb begin
    next_state = state;
    next_idx   = idx;
    tx_byte    = 8'h00;
    unique case (state)
      IDLE: begin
        if (trigger) begin
          next_state = PREFIX;
          next_idx   = 3'd0;
        end
      end
      PREFIX: begin
        tx_byte = 8'h51;
        if (fire)
          next_state = TENS;
      end
      TENS: begin
        tx_byte = 8'h30 + {4'd0, tens[idx]};
        if (fire)
          next_state = ONES;
      end
      ONES: begin
        tx_byte = 8'h30 + {4'd0, ones[idx]};
        if (fire)
          next_state = (idx == LAST_IDX) ? EOL : SEP;
      end
      SEP: begin
        tx_byte = 8'h2C;
        if (fire) begin
          next_state = TENS;
          next_idx   = idx + 3'd1;
        end
      end
      EOL: begin
        tx_byte = 8'h0A;
        if (fire)
          next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
        next_idx   = 3'd0;
      end
    endcase
  end

  assign tx_data  = tx_byte;
  assign tx_valid = (state != IDLE);
  assign busy     = (state != IDLE);

endmodule

// File: doc/sr_q_csv_serializer.md
# sr_q_csv_serializer

Snapshots the five integer Schumann-resonance Q values produced by the Q-factor drift generator (`q_scaled_packed`) and streams them out as one ASCII CSV line per snapshot over a valid/ready byte interface. It sits between the drift generator and the host export path (UART TX / capture FIFO), and is the consumer side of the CSV export data.

## Interface
- `WIDTH`, 18: bit width of each packed signed Q value.
- `NUM_HARMONICS`, 5: number of packed values; the line format is fixed for 5.
- `PERIOD`, 256: number of `clk_en` pulses between automatic snapshots; legal range 2..65535.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `clk_en`  in  1  sample-rate strobe, the same strobe that drives the drift generator.
- `enable`  in  1  gates automatic periodic snapshots; `snap_req` still works when it is low.
- `snap_req`  in  1  single-cycle manual snapshot request.
- `q_scaled_packed`  in  NUM_HARMONICS*WIDTH  signed integer Q values; value 0 occupies the LSBs.
- `tx_data`  out  8  ASCII byte.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  the sink accepts the byte.
- `busy`  out  1  a line is in progress.
- `overrun_count`  out  8  count of dropped triggers; saturates at 255.

## Operation
- **Trigger.**
  - The trigger is `snap_req`, OR'd with a periodic tick.
  - The periodic tick uses a 16-bit counter that advances on each `clk_en` while `enable` is high. It wraps from PERIOD-1 to 0, and the tick fires on the `clk_en` cycle where the counter wraps.
  - The counter holds its value while `enable` is low.
- **Snapshot.**
  - A trigger is accepted only in IDLE.
  - On acceptance, each value is clamped to 0..99: negative values become 0 and values >99 become 99.
  - Each clamped value is split into a tens digit and a ones digit (0..9). The digits are registered in a 5x2 digit buffer.
  - Later changes on `q_scaled_packed` do not affect the line in flight.
- **Overrun.**
  - A trigger outside IDLE is dropped and increments `overrun_count`, saturating at 255.
  - This includes a trigger in the same cycle as the final `\n` handshake.
  - Simultaneous `snap_req` and periodic tick count as one trigger.
- **Line format.** 16 bytes: `Q`(0x51), d0t, d0o, `,`(0x2C), d1t, d1o, `,`, d2t, d2o, `,`, d3t, d3o, `,`, d4t, d4o, `\n`(0x0A). Each digit is encoded as 0x30 + digit.
- **FSM states:** IDLE, PREFIX, TENS, ONES, SEP, EOL. A 3-bit index `idx` runs 0..4.
  - IDLE -> PREFIX on an accepted trigger; `idx` = 0.
  - PREFIX -> TENS on handshake.
  - TENS -> ONES on handshake.
  - ONES -> SEP on handshake if `idx` < 4; ONES -> EOL on handshake if `idx` = 4.
  - SEP -> TENS on handshake, with `idx` + 1.
  - EOL -> IDLE on handshake.
- **Handshake.**
  - A byte transfers when `tx_valid` && `tx_ready`.
  - While `tx_valid` = 1 and `tx_ready` = 0, `tx_data` and `tx_valid` are held stable.
  - `tx_valid` never drops without a handshake, except on reset.
- **Outputs.** `busy` = (state != IDLE). `tx_valid` = (state != IDLE). `tx_data` is a registered or state-decoded byte.
- **Reset.**
  - Asynchronous reset sets state to IDLE and `idx` = 0.
  - `tx_valid` = 0, `tx_data` = 0x00, `busy` = 0, `overrun_count` = 0.
  - The period counter and the digit buffer are cleared to 0.
  - Reset mid-line aborts the line immediately. No resume and no trailing `\n` are emitted.

## Timing
- `q_scaled_packed` is sampled at the clock edge where the accepted trigger is high.
- `tx_valid`/`busy` go high on the cycle after the trigger, presenting `Q`.
- With `tx_ready` held at 1:
  - one byte transfers per cycle, 16 cycles per line;
  - `busy` falls on the cycle after the `\n` handshake;
  - the earliest next accepted trigger is on that cycle, so the minimum line-to-line spacing is 17 cycles.
- Each cycle of `tx_ready` = 0 adds exactly one cycle to the line.
- `overrun_count` updates on the clock edge after the dropped trigger.
- With `clk_en` every cycle and `tx_ready` = 1, PERIOD >= 17 guarantees zero overruns.

## Test plan
- **Basic line.** Packed values {7, 9, 15, 8, 7} (value 0 first), `snap_req` pulse, `tx_ready` = 1.
  - Exactly 16 bytes: 0x51,0x30,0x37,0x2C,0x30,0x39,0x2C,0x31,0x35,0x2C,0x30,0x38,0x2C,0x30,0x37,0x0A.
  - `tx_valid` is first high one cycle after the pulse; `busy` is low after the last byte.
- **Clamping.** Values {-3, 0, 99, 100, 131071}.
  - Digit payload is "00,00,99,99,99".
- **Backpressure.** Basic line with `tx_ready` = 0 for 5 cycles while the 4th byte (`,`) is presented.
  - `tx_data` holds 0x2C and `tx_valid` stays 1 for all 5 cycles.
  - The line completes in 21 cycles with no byte duplicated or lost.
- **Overrun and input isolation.** `snap_req` again at byte 8; also change `q_scaled_packed` mid-line.
  - `overrun_count` = 1.
  - The in-flight line is unaltered and still carries the snapshot values.
  - 300 dropped triggers -> `overrun_count` = 255.
- **Periodic mode.** PERIOD = 32, `clk_en` every cycle, `enable` = 1, `tx_ready` = 1.
  - Lines start exactly every 32 cycles, with `overrun_count` = 0.
  - Dropping `enable` stops lines; restoring it resumes them, with the counter continuing from its held value.
- **Reset mid-line.** Assert `rst` for 1 cycle at byte 6.
  - `tx_valid`, `busy` and `overrun_count` go to 0 asynchronously.
  - The next `snap_req` produces a complete 16-byte line starting with 0x51.
